// File: rtl/router_pkt_ctrl.sv
// Packet-sequencing FSM for the 1x3 router: header decode, FIFO write enables, full stalls.
// Define ROUTER_SOFT_RST_EN to build the per-FIFO read watchdogs and their packet-abort path.
module router_pkt_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy,
    output logic [2:0] soft_reset
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [1:0] sel_idx;
    logic [3:0] empty_pad, full_pad;
    logic       empty_sel, full_sel;
    logic       hdr_valid;
    logic       abort;
    logic       wr_en;
    logic       unused_hdr;

    // Only the two address bits of the header matter here; length is handled downstream.
    assign unused_hdr = ^data_in[7:2];
    assign hdr_valid  = pkt_valid && (data_in[1:0] != 2'd3);

    // Flags are padded so that address 3 selects a harmless zero instead of running off the end.
    assign sel_idx   = (state_q == DECODE_ADDRESS) ? data_in[1:0] : addr_q;
    assign empty_pad = {1'b0, fifo_empty};
    assign full_pad  = {1'b0, fifo_full};
    assign empty_sel = empty_pad[sel_idx];
    assign full_sel  = full_pad[sel_idx];

`ifdef ROUTER_SOFT_RST_EN
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       soft_reset_q, soft_reset_d;
    logic [3:0]       sr_pad;

    always_comb begin
        soft_reset_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (fifo_empty[i] || read_enb[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
                cnt_d[i]        = '0;
                soft_reset_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            soft_reset_q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            soft_reset_q <= soft_reset_d;
        end
    end

    // A timeout on the FIFO this packet targets drops the packet; idle decode is never aborted.
    assign sr_pad     = {1'b0, soft_reset_q};
    assign abort      = sr_pad[addr_q] && (state_q != DECODE_ADDRESS);
    assign soft_reset = soft_reset_q;
`else
    localparam int unused_cfg = TIMEOUT + CNT_W;
    logic [2:0] unused_rd;

    assign unused_rd  = read_enb;
    assign abort      = 1'b0;
    assign soft_reset = 3'b000;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if ((state_q == DECODE_ADDRESS) && hdr_valid) begin
            addr_d = data_in[1:0];
        end
        if (abort) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (hdr_valid) begin
                        state_d = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_sel) state_d = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (full_sel)        state_d = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!full_sel) state_d = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        state_d = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_d = LOAD_PARITY;
                    else                    state_d = LOAD_DATA;
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_d = full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    assign detect_add  = (state_q == DECODE_ADDRESS);
    assign lfd_state   = (state_q == LOAD_FIRST_DATA);
    assign ld_state    = (state_q == LOAD_DATA);
    assign laf_state   = (state_q == LOAD_AFTER_FULL);
    assign full_state  = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg = (state_q == CHECK_PARITY_ERROR);
    assign busy        = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

    assign wr_en     = lfd_state || ld_state || laf_state || (state_q == LOAD_PARITY);
    assign write_enb = wr_en ? (3'b001 << addr_q) : 3'b000;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Bench for router_pkt_ctrl: directed packet scenarios plus random traffic against a phase model.
module tb_router_pkt_ctrl;
    localparam int TIMEOUT = 30;

    logic       clk;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;
    logic [2:0] soft_reset;

    int n_pass  = 0;
    int n_total = 0;

    router_pkt_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clock        (clk),
        .reset        (rst),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .read_enb     (read_enb),
        .write_enb    (write_enb),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .busy         (busy),
        .soft_reset   (soft_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [12:0] dut_vec = {write_enb, detect_add, lfd_state, ld_state, laf_state,
                           full_state, rst_int_reg, busy, soft_reset};

    // Packet phases of the reference model: what the controller is doing with the packet.
    typedef enum int {P_IDLE, P_WAIT, P_HDR, P_BODY, P_FULL, P_RESUME, P_PAR, P_CHK} phase_t;
    phase_t     m_ph   = P_IDLE;
    int         m_addr = 0;
    int         m_run [3];
    logic [2:0] m_sr   = 3'b000;

    function automatic logic [12:0] exp_vec();
        logic       wr;
        logic [2:0] we;
        wr = (m_ph == P_HDR) || (m_ph == P_BODY) || (m_ph == P_PAR) || (m_ph == P_RESUME);
        we = wr ? (3'b001 << m_addr) : 3'b000;
        return {we, m_ph == P_IDLE, m_ph == P_HDR, m_ph == P_BODY, m_ph == P_RESUME,
                m_ph == P_FULL, m_ph == P_CHK, !((m_ph == P_IDLE) || (m_ph == P_BODY)), m_sr};
    endfunction

    // One clock: the model digests the inputs seen at the edge, then outputs settle.
    task automatic step();
        logic [2:0] nsr;
        logic       ab;
        int         a;
        @(posedge clk);
        if (rst) begin
            m_ph   = P_IDLE;
            m_addr = 0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_sr   = 3'b000;
        end else begin
            nsr = 3'b000;
            ab  = 1'b0;
`ifdef ROUTER_SOFT_RST_EN
            for (int i = 0; i < 3; i++) begin
                if (fifo_empty[i] || read_enb[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == TIMEOUT) begin
                        nsr[i]   = 1'b1;
                        m_run[i] = 0;
                    end
                end
            end
            ab = m_sr[m_addr] && (m_ph != P_IDLE);
`endif
            if (ab) m_ph = P_IDLE;
            else begin
                case (m_ph)
                    P_IDLE: if (pkt_valid && data_in[1:0] != 2'd3) begin
                        a      = int'(data_in[1:0]);
                        m_addr = a;
                        m_ph   = fifo_empty[a] ? P_HDR : P_WAIT;
                    end
                    P_WAIT:   if (fifo_empty[m_addr]) m_ph = P_HDR;
                    P_HDR:    m_ph = P_BODY;
                    P_BODY:   if (fifo_full[m_addr]) m_ph = P_FULL;
                              else if (!pkt_valid) m_ph = P_PAR;
                    P_FULL:   if (!fifo_full[m_addr]) m_ph = P_RESUME;
                    P_RESUME: m_ph = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
                    P_PAR:    m_ph = P_CHK;
                    P_CHK:    m_ph = fifo_full[m_addr] ? P_FULL : P_IDLE;
                    default:  m_ph = P_IDLE;
                endcase
            end
            m_sr = nsr;
        end
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid = 1'b0; data_in = 8'h00; parity_done = 1'b0; low_pkt_valid = 1'b0;
        fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_total++;
        if ({detect_add, busy} !== 2'b10) $display("FAIL reset_state: detect_add/busy=%b want 10", {detect_add, busy});
        else n_pass++;
        n_total++;
        if ({write_enb, soft_reset} !== 6'b0) $display("FAIL reset_outs: write_enb/soft_reset=%b want 000000", {write_enb, soft_reset});
        else n_pass++;
        n_total++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_vec: got %b want %b", dut_vec, exp_vec());
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_packet();
        int we_cyc = 0, lfd_cyc = 0;
        pkt_valid = 1'b1; data_in = 8'h11;
        step();
        if (write_enb == 3'b010) we_cyc++;
        if (lfd_state) lfd_cyc++;
        for (int k = 0; k < 4; k++) begin
            data_in = 8'($urandom);
            step();
            if (write_enb == 3'b010) we_cyc++;
            if (lfd_state) lfd_cyc++;
        end
        pkt_valid = 1'b0; data_in = 8'h5a;
        step();
        if (write_enb == 3'b010) we_cyc++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL pkt_parity_busy: busy=%b want 1", busy);
        else n_pass++;
        step();
        n_total++;
        if ({rst_int_reg, write_enb} !== 4'b1000) $display("FAIL pkt_check: rst_int/we=%b want 1000", {rst_int_reg, write_enb});
        else n_pass++;
        step();
        n_total++;
        if (detect_add !== 1'b1) $display("FAIL pkt_done: detect_add=%b want 1", detect_add);
        else n_pass++;
        n_total++;
        if (we_cyc != 6) $display("FAIL pkt_we_cycles: got %0d want 6", we_cyc);
        else n_pass++;
        n_total++;
        if (lfd_cyc != 1) $display("FAIL pkt_lfd_cycles: got %0d want 1", lfd_cyc);
        else n_pass++;
    endtask

    task automatic test_bad_addr();
        logic [7:0] hdrs [3] = '{8'h03, 8'hff, 8'h87};
        pkt_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = hdrs[k];
            step();
            n_total++;
            if ({detect_add, write_enb} !== 4'b1000) $display("FAIL bad_addr_%0d: detect/we=%b want 1000", k, {detect_add, write_enb});
            else n_pass++;
        end
        pkt_valid = 1'b0;
    endtask

    task automatic test_wait_empty();
        fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 8'h06;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if ({busy, detect_add, lfd_state, write_enb} !== 6'b100000) $display("FAIL wait_%0d: busy/det/lfd/we=%b want 100000", k, {busy, detect_add, lfd_state, write_enb});
            else n_pass++;
        end
        fifo_empty = 3'b111;
        step();
        n_total++;
        if ({lfd_state, write_enb} !== 4'b1100) $display("FAIL wait_release: lfd/we=%b want 1100", {lfd_state, write_enb});
        else n_pass++;
        step();
        pkt_valid = 1'b0;
        step();
        step();
        step();
        n_total++;
        if (detect_add !== 1'b1) $display("FAIL wait_done: detect_add=%b want 1", detect_add);
        else n_pass++;
    endtask

    task automatic test_full();
        pkt_valid = 1'b1; data_in = 8'h10;
        step();
        step();
        fifo_full = 3'b001;
        step();
        n_total++;
        if ({full_state, busy, write_enb} !== 5'b11000) $display("FAIL full_enter: full/busy/we=%b want 11000", {full_state, busy, write_enb});
        else n_pass++;
        step();
        n_total++;
        if (full_state !== 1'b1) $display("FAIL full_hold: full_state=%b want 1", full_state);
        else n_pass++;
        fifo_full = 3'b000;
        step();
        n_total++;
        if ({laf_state, write_enb} !== 4'b1001) $display("FAIL full_resume: laf/we=%b want 1001", {laf_state, write_enb});
        else n_pass++;
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        step();
        n_total++;
        if ({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy, write_enb} !== 10'b0000001001)
            $display("FAIL full_to_parity: flags/we=%b want 0000001001", {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy, write_enb});
        else n_pass++;
        low_pkt_valid = 1'b0;
        step();
        step();
        n_total++;
        if (detect_add !== 1'b1) $display("FAIL full_done: detect_add=%b want 1", detect_add);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        pkt_valid = 1'b1; data_in = 8'h02;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; pkt_valid = 1'b0;
        n_total++;
        if ({detect_add, write_enb} !== 4'b1000) $display("FAIL reset_mid: detect/we=%b want 1000", {detect_add, write_enb});
        else n_pass++;
    endtask

    task automatic test_soft_reset();
        int early = 0;
        pkt_valid = 1'b1; data_in = 8'h01;
        step();
        step();
        fifo_empty = 3'b101; read_enb = 3'b000;
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            if (soft_reset !== 3'b000 || ld_state !== 1'b1) early++;
        end
        n_total++;
        if (early != 0) $display("FAIL sr_early: %0d cycles with pulse or lost LOAD_DATA, want 0", early);
        else n_pass++;
        step();
`ifdef ROUTER_SOFT_RST_EN
        n_total++;
        if ({soft_reset, ld_state} !== 4'b0101) $display("FAIL sr_pulse: soft_reset/ld=%b want 0101", {soft_reset, ld_state});
        else n_pass++;
        pkt_valid = 1'b0;
        step();
        n_total++;
        if ({detect_add, soft_reset} !== 4'b1000) $display("FAIL sr_abort: detect/soft_reset=%b want 1000", {detect_add, soft_reset});
        else n_pass++;
`else
        n_total++;
        if ({soft_reset, ld_state} !== 4'b0001) $display("FAIL sr_disabled: soft_reset/ld=%b want 0001", {soft_reset, ld_state});
        else n_pass++;
`endif
        pkt_valid = 1'b0; fifo_empty = 3'b111;
        for (int k = 0; k < 4; k++) step();
        n_total++;
        if (detect_add !== 1'b1) $display("FAIL sr_idle: detect_add=%b want 1", detect_add);
        else n_pass++;
        early = 0;
        fifo_empty = 3'b101;
        for (int k = 1; k < TIMEOUT - 1; k++) begin
            step();
            if (soft_reset !== 3'b000) early++;
        end
        read_enb = 3'b010;
        step();
        read_enb = 3'b000;
        for (int k = 0; k < 10; k++) begin
            step();
            if (soft_reset !== 3'b000) early++;
        end
        n_total++;
        if (early != 0) $display("FAIL sr_read_clears: %0d pulse cycles, want 0", early);
        else n_pass++;
        fifo_empty = 3'b111;
        step();
    endtask

    task automatic test_random();
        int bad = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 800; c++) begin
            bit starve;
            starve        = (c >= 400);
            rst           = ($urandom_range(199) == 0);
            pkt_valid     = ($urandom_range(99) < 70);
            data_in       = 8'($urandom);
            parity_done   = ($urandom_range(99) < 20);
            low_pkt_valid = ($urandom_range(99) < 20);
            for (int i = 0; i < 3; i++) begin
                fifo_full[i]  = ($urandom_range(99) < 12);
                fifo_empty[i] = starve ? ($urandom_range(99) < 3) : ($urandom_range(99) < 70);
                read_enb[i]   = starve ? ($urandom_range(99) < 3) : ($urandom_range(99) < 30);
            end
            step();
            n_total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random_c%0d: got %b want %b", c, dut_vec, exp_vec());
            end else n_pass++;
        end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_packet();
        test_bad_addr();
        test_wait_empty();
        test_full();
        test_reset_mid();
        test_soft_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
